// File: rtl/gen_collector.sv
// rtl/gen_collector.sv - caller-side controller for start/ready/valid/done HLS generators
//
// Purpose: accepts a command carrying n, launches the generator with a one-cycle
// start pulse, drains the generator's stream into a small FIFO while applying
// backpressure through gen_ready, serves the FIFO on a downstream valid/ready
// port, then pulses seq_done with the number of items collected.
//
// Optional build macro: GEN_COLLECTOR_TIMEOUT_EN adds a stall timeout in RUN and
// the timeout_err output.
//
// Ports:
//   __clock, __reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_n   command handshake and generator argument
//   gen_n, gen_start, gen_reset generator argument, launch pulse, generator reset
//   gen_ready/gen_valid/gen_done/gen_output  generator output stream
//   out_valid/out_ready/out_data downstream item stream (FIFO head)
//   seq_done, seq_count         completion pulse and collected item count
//   busy                        high whenever not idle
//   timeout_err                 (macro only) sticky stall-timeout flag
module gen_collector #(
  parameter int W                 = 32,
  parameter int DEPTH             = 4,
  parameter int CW                = 16,
  parameter int DONE_CARRIES_DATA = 0,
  parameter int TIMEOUT           = 1024
) (
  input  logic          __clock,
  input  logic          __reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_n,
  output logic [W-1:0]  gen_n,
  output logic          gen_start,
  output logic          gen_reset,
  output logic          gen_ready,
  input  logic          gen_valid,
  input  logic          gen_done,
  input  logic [W-1:0]  gen_output,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          seq_done,
  output logic [CW-1:0] seq_count,
  output logic          busy
`ifdef GEN_COLLECTOR_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("gen_collector: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  gen_n_q, gen_n_d;
  logic          gen_start_q, gen_start_d;
  logic          gen_reset_q, gen_reset_d;
  logic          seq_done_q, seq_done_d;
  logic [CW-1:0] seq_count_q, seq_count_d;
  logic [CW-1:0] items_q, items_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_count_q, fifo_count_d;
  logic [W-1:0]  mem_q [DEPTH];

`ifdef GEN_COLLECTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_q, stall_d;
  logic          to_pend_q, to_pend_d;
  logic          timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif

  logic beat_fire, push, pop;

  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);
  // Ready depends only on current occupancy, so a full FIFO holds the
  // generator off even if the downstream pops in the same cycle.
  assign gen_ready = (state_q == S_RUN) && (fifo_count_q < DEPTH_C);
  assign out_valid = (fifo_count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

  assign gen_n     = gen_n_q;
  assign gen_start = gen_start_q;
  assign gen_reset = gen_reset_q;
  assign seq_done  = seq_done_q;
  assign seq_count = seq_count_q;

  assign beat_fire = gen_valid && gen_ready;
  // The done beat is a pure marker unless the generator puts data on it.
  assign push      = beat_fire && (!gen_done || (DONE_CARRIES_DATA != 0));
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    gen_n_d      = gen_n_q;
    gen_start_d  = 1'b0;
    gen_reset_d  = 1'b0;
    seq_done_d   = 1'b0;
    seq_count_d  = seq_count_q;
    items_d      = items_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
    stall_d       = '0;
    to_pend_d     = to_pend_q;
    timeout_err_d = timeout_err_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + (AW+1)'(1);
      2'b01:   fifo_count_d = fifo_count_q - (AW+1)'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          gen_n_d     = cmd_n;
          items_d     = '0;
          gen_start_d = 1'b1;
          state_d     = S_START;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
          to_pend_d     = 1'b0;
          timeout_err_d = 1'b0;
`endif
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (push && items_q != '1) items_d = items_q + CW'(1);
        if (beat_fire && gen_done) state_d = S_FLUSH;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
        // Any valid cycle proves the generator is alive, even if held off.
        stall_d = gen_valid ? '0 : stall_q + TW'(1);
        if (!gen_valid && stall_q == TW'(TIMEOUT - 1)) begin
          gen_reset_d = 1'b1;
          to_pend_d   = 1'b1;
          stall_d     = '0;
          state_d     = S_FLUSH;
        end
`endif
      end
      S_FLUSH: begin
        if (fifo_count_q == '0) begin
          seq_done_d  = 1'b1;
          seq_count_d = items_q;
          state_d     = S_IDLE;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
          timeout_err_d = timeout_err_q | to_pend_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge __clock or negedge __reset_n) begin
    if (!__reset_n) begin
      state_q      <= S_IDLE;
      gen_n_q      <= '0;
      gen_start_q  <= 1'b0;
      gen_reset_q  <= 1'b1;
      seq_done_q   <= 1'b0;
      seq_count_q  <= '0;
      items_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
      stall_q       <= '0;
      to_pend_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gen_n_q      <= gen_n_d;
      gen_start_q  <= gen_start_d;
      gen_reset_q  <= gen_reset_d;
      seq_done_q   <= seq_done_d;
      seq_count_q  <= seq_count_d;
      items_q      <= items_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
`ifdef GEN_COLLECTOR_TIMEOUT_EN
      stall_q       <= stall_d;
      to_pend_q     <= to_pend_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge __clock) begin
    if (push) mem_q[wr_ptr_q] <= gen_output;
  end

endmodule
